// File: rtl/mant_add_pkg.sv
// ---------------------------------------------------------------------------
// mant_add_pkg
// Shared constants for the mantissa-adder scheduler.
//   MANT_WIDTH : default operand / sum width of the shared mantissa adder
//   CNT_W      : width of the adder settle-cycle counter (ADD_CYCLES <= 7)
//   ST_*       : scheduler FSM state encodings
// ---------------------------------------------------------------------------
package mant_add_pkg;

    localparam int MANT_WIDTH = 48;
    localparam int CNT_W      = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Counter load value for an adder that needs add_cycles cycles to settle;
    // the counter reaches zero in the last ADD cycle.
    function automatic logic [CNT_W-1:0] add_cnt_init(input int add_cycles);
        return CNT_W'(add_cycles - 1);
    endfunction

endpackage

// File: rtl/mant_adder.sv
// ---------------------------------------------------------------------------
// mant_adder
// Combinational unsigned carry-select adder for mantissas. The lower half
// ripples; the upper half is computed for both carry-in values and the low
// half's carry selects between them.
//   a, b      : unsigned operands
//   sum       : (a + b) mod 2^WIDTH
//   carry_out : carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module mant_adder
    import mant_add_pkg::*;
#(
    parameter int WIDTH = MANT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [LO_W:0] lo_s;
    logic [HI_W:0] hi_c0_s;
    logic [HI_W:0] hi_c1_s;

    assign lo_s    = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]};
    assign hi_c0_s = {1'b0, a[WIDTH-1:LO_W]} + {1'b0, b[WIDTH-1:LO_W]};
    assign hi_c1_s = {1'b0, a[WIDTH-1:LO_W]} + {1'b0, b[WIDTH-1:LO_W]}
                   + (HI_W+1)'(1);

    // Select the upper half precomputed for the actual low-half carry.
    always_comb begin
        if (lo_s[LO_W]) begin
            sum       = {hi_c1_s[HI_W-1:0], lo_s[LO_W-1:0]};
            carry_out = hi_c1_s[HI_W];
        end else begin
            sum       = {hi_c0_s[HI_W-1:0], lo_s[LO_W-1:0]};
            carry_out = hi_c0_s[HI_W];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: picks the first set req_valid bit at or
// above rr_ptr, wrapping modulo NUM_REQ.
//   req_valid    : per-requester request valid
//   rr_ptr       : highest-priority requester index for this search
//   grant_onehot : one-hot grant (zero when nothing is requested)
//   grant_idx    : index of the granted requester (0 when no grant)
//   any_grant    : a requester was selected
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        logic [ID_W:0] cand;
        logic          found;
        grant_onehot = '0;
        grant_idx    = '0;
        any_grant    = 1'b0;
        cand         = '0;
        found        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit so the wrap subtraction never overflows.
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found                           = 1'b1;
                grant_onehot[cand[ID_W-1:0]]    = 1'b1;
                grant_idx                       = cand[ID_W-1:0];
            end else begin
                found = found;
            end
        end
        any_grant = found;
    end

endmodule

// File: rtl/mant_add_scheduler.sv
// ---------------------------------------------------------------------------
// mant_add_scheduler
// Shares one mantissa adder among NUM_REQ product-accumulate lanes. A
// round-robin arbiter grants one lane, its operands are registered, the
// adder is given ADD_CYCLES cycles to settle (multicycle path), and the
// result is returned on a tagged valid/ready response channel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-lane request handshake (ready one-hot or zero)
//   req_a, req_b        : packed operands, lane i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : lane that owns the response
//   rsp_sum, rsp_carry  : A+B modulo 2^WIDTH and carry out of the MSB
//   busy                : FSM is not idle
// ---------------------------------------------------------------------------
module mant_add_scheduler
    import mant_add_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = MANT_WIDTH,
    parameter int ADD_CYCLES = 2,
    parameter int ID_W       = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     busy
);

    logic [1:0]       state_q,     state_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] op_a_q,      op_a_d;
    logic [WIDTH-1:0] op_b_q,      op_b_d;
    logic [ID_W-1:0]  op_id_q,     op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
    logic             rsp_carry_q, rsp_carry_d;

    logic [NUM_REQ-1:0] grant_onehot_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic               any_grant_s;
    logic [WIDTH-1:0]   add_sum_s;
    logic               add_carry_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid    (req_valid),
        .rr_ptr       (rr_ptr_q),
        .grant_onehot (grant_onehot_s),
        .grant_idx    (grant_idx_s),
        .any_grant    (any_grant_s)
    );

    // Fed only from the operand registers, so its inputs are stable for the
    // whole ADD state and the result may take ADD_CYCLES cycles to settle.
    mant_adder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a         (op_a_q),
        .b         (op_b_q),
        .sum       (add_sum_s),
        .carry_out (add_carry_s)
    );

    // Requests are only accepted while idle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_ready = grant_onehot_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath-capture logic of the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        case (state_q)
            ST_IDLE: begin
                if (any_grant_s) begin
                    op_a_d  = req_a[grant_idx_s*WIDTH +: WIDTH];
                    op_b_d  = req_b[grant_idx_s*WIDTH +: WIDTH];
                    op_id_d = grant_idx_s;
                    cnt_d   = add_cnt_init(ADD_CYCLES);
                    // Pointer only advances on a grant, which bounds waiting.
                    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx_s + ID_W'(1);
                    end
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (cnt_q == CNT_W'(0)) begin
                    rsp_sum_d   = add_sum_s;
                    rsp_carry_d = add_carry_s;
                    rsp_id_d    = op_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                // Response fields are left untouched here, so they hold
                // steady under backpressure.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter, operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mant_add_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mant_add_scheduler
// Scoreboard bench: a cycle model of the round-robin grant pushes the
// expected response (id, A+B, carry, due cycle) when a grant is expected;
// the response channel is compared against the queue head every cycle.
// ---------------------------------------------------------------------------
module tb_mant_add_scheduler;

    localparam int NR = 4;
    localparam int W  = 48;
    localparam int IW = 2;
    localparam int AC = 2;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic              busy;

    mant_add_scheduler #(
        .NUM_REQ    (NR),
        .WIDTH      (W),
        .ADD_CYCLES (AC),
        .ID_W       (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  sum;
        logic          carry;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_ptr = 0;
    logic m_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Monitor and reference model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [NR-1:0] exp_ready;
        logic          exp_valid;
        logic [W:0]    full;
        int            gidx;
        exp_t          e;
        cyc++;
        if (!rst_n) begin
            check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check_eq("rst_req_ready", 64'(req_ready), 64'd0);
            check_eq("rst_busy",      64'(busy),      64'd0);
            check_eq("rst_rsp_id",    64'(rsp_id),    64'd0);
            check_eq("rst_rsp_sum",   64'(rsp_sum),   64'd0);
            check_eq("rst_rsp_carry", 64'(rsp_carry), 64'd0);
            sb.delete();
            m_ptr  = 0;
            m_busy = 1'b0;
        end else begin
            exp_valid = (sb.size() > 0) && (cyc >= sb[0].due);
            check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            check_eq("busy",      64'(busy),      64'(m_busy));
            exp_ready = '0;
            gidx      = -1;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    if (gidx < 0 && req_valid[(m_ptr + k) % NR]) begin
                        gidx = (m_ptr + k) % NR;
                    end
                end
                if (gidx >= 0) exp_ready[gidx] = 1'b1;
            end
            check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
            if (exp_valid) begin
                check_eq("rsp_id",    64'(rsp_id),    64'(sb[0].id));
                check_eq("rsp_sum",   64'(rsp_sum),   64'(sb[0].sum));
                check_eq("rsp_carry", 64'(rsp_carry), 64'(sb[0].carry));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    m_busy = 1'b0;
                end
            end
            if (gidx >= 0) begin
                full    = {1'b0, req_a[gidx*W +: W]} + {1'b0, req_b[gidx*W +: W]};
                e.id    = IW'(gidx);
                e.sum   = full[W-1:0];
                e.carry = full[W];
                e.due   = cyc + AC + 1;
                sb.push_back(e);
                m_ptr   = (gidx + 1) % NR;
                m_busy  = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic one_shot(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        set_op(i, a, b);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        step(1);
        req_valid = '0;
        step(5);
    endtask

    // Directed and random stimulus.
    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Single request and carry wrap cases.
        one_shot(0, 48'h0000_0000_0001, 48'h0000_0000_0002);
        one_shot(1, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001);
        one_shot(2, 48'h8000_0000_0000, 48'h8000_0000_0000);

        // Backpressure: consumer stalls for several cycles.
        rsp_ready = 1'b0;
        set_op(3, 48'h1234_5678_9ABC, 48'h0FED_CBA9_8765);
        req_valid = 4'b1000;
        step(1);
        req_valid = '0;
        step(8);
        rsp_ready = 1'b1;
        step(3);

        // Reset in the middle of ADD: no response, pointer back to 0.
        set_op(1, 48'h0000_1111_2222, 48'h0000_3333_4444);
        req_valid = 4'b0010;
        step(1);
        req_valid = '0;
        step(1);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;

        // Round robin with all lanes requesting continuously.
        for (int i = 0; i < NR; i++) begin
            set_op(i, 48'h0100_0000_0000 * 48'(i + 1) + 48'(i), 48'h0000_00AB_0000 + 48'(i));
        end
        req_valid = 4'b1111;
        step(22);
        req_valid = '0;
        step(6);

        // Pointer skip: after grants to 0 and 1 the pointer sits at 2.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        one_shot(0, 48'h0000_0000_0010, 48'h0000_0000_0020);
        one_shot(1, 48'h0000_0000_0030, 48'h0000_0000_0040);
        set_op(0, 48'h0000_0000_0050, 48'h0000_0000_0060);
        set_op(1, 48'h0000_0000_0070, 48'h0000_0000_0080);
        req_valid = 4'b0011;
        step(1);
        req_valid = 4'b0010;
        step(5);
        req_valid = '0;
        step(5);

        // Random traffic with random backpressure and operand churn.
        for (int t = 0; t < 400; t++) begin
            req_valid = NR'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            set_op($urandom_range(0, NR - 1), rnd48(), rnd48());
            step(1);
        end

        // Drain.
        req_valid = '0;
        rsp_ready = 1'b1;
        step(10);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mant_add_scheduler.md
Name: mant_add_scheduler

Overview:
- Shares one 48-bit mantissa adder among NUM_REQ requesters in the FP32 matrix-multiplier datapath. Requesters are the per-PE product-accumulate lanes.
- A round-robin arbiter grants one requester at a time and registers its operands.
- The adder path is treated as a multicycle path. The result is sampled after ADD_CYCLES cycles and returned on a single tagged response channel with a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 48, operand and sum width.
- ADD_CYCLES, 2, cycles allowed for the combinational adder to settle (1..7).
- ID_W, 2, requester-id width; must equal clog2(NUM_REQ).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_ready, output, NUM_REQ, per-requester accept; one-hot or zero.
- req_a, input, NUM_REQ*WIDTH, operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b, input, NUM_REQ*WIDTH, operand B; same packing as req_a.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, consumer accepts response.
- rsp_id, output, ID_W, index of the requester that owns the response.
- rsp_sum, output, WIDTH, A+B modulo 2^WIDTH.
- rsp_carry, output, 1, carry out of bit WIDTH-1.
- busy, output, 1, high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, cycle counter=0, operand regs=0.
- Reset values of outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0.
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the granted requester when any req_valid is set, else 0.
  - Grant rule: the first set req_valid bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On a grant: capture A, B and id; set cnt=ADD_CYCLES-1; set rr_ptr=(grant+1) mod NUM_REQ; go to ADD.
- ADD:
  - req_ready=0.
  - Operand registers feed the adder sub-module and are stable for the whole state.
  - If cnt==0: register sum and carry into rsp_sum/rsp_carry, set rsp_id, assert rsp_valid, go to RESP. Otherwise decrement cnt.
  - With ADD_CYCLES=1, the state spends exactly one cycle in ADD.
- RESP:
  - rsp_valid=1; rsp_sum, rsp_carry and rsp_id are held stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: deassert rsp_valid next cycle and go to IDLE.
  - No new grant is issued in the handshake cycle. The next grant is possible one cycle later.
- Latency: from the grant cycle to rsp_valid is ADD_CYCLES+1 cycles. Throughput is at most one op per ADD_CYCLES+2 cycles.
- Fairness: rr_ptr moves only on a grant. A requester holding req_valid waits at most NUM_REQ-1 other grants.
- Requester contract:
  - req_valid may drop without a grant; the request is then simply not taken.
  - Operands are sampled only in the grant cycle.
- Arithmetic is unsigned. A carry out of the MSB sets rsp_carry; the sum wraps.
- Reset asserted mid-ADD or mid-RESP: the in-flight operation is discarded, no response is issued, and the block returns to IDLE with rr_ptr=0.
- Requests presented while the FSM is in ADD or RESP see req_ready=0 and must hold valid.

Decomposition:
- Shared package mant_add_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_RESP=2'd2;
  - the default WIDTH=48.
- Sub-module rr_arbiter (NUM_REQ) carries the combinational round-robin grant from req_valid and rr_ptr, with outputs grant_onehot, grant_idx and any_grant.
- The adder is a separate combinational 48-bit ripple/carry-select adder instance: inputs A, B; outputs sum, carry_out.

Test Plan:
- Single request: after reset, req_valid=4'b0001, A=48'h0000_0000_0001, B=48'h0000_0000_0002, rsp_ready=1.
  - req_ready[0] rises in cycle 0.
  - rsp_valid rises in cycle 3 (ADD_CYCLES=2) with rsp_sum=48'h3, rsp_carry=0, rsp_id=0.
- Carry wrap: A=48'hFFFF_FFFF_FFFF, B=48'h1 -> rsp_sum=0, rsp_carry=1. Also A=B=48'h8000_0000_0000 -> rsp_sum=0, rsp_carry=1.
- Round-robin: all four req_valid held high continuously with distinct operands.
  - Grants in order 0,1,2,3,0.
  - rsp_id follows the same order, with each rsp_sum matching its requester's A+B.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_valid, rsp_sum and rsp_id stay constant.
  - req_ready stays 0 and busy=1.
  - After rsp_ready=1, rsp_valid falls the next cycle.
- Reset mid-operation: assert rst_n=0 during ADD, release 2 cycles later -> all outputs at their reset values, no rsp_valid pulse, and the next grant goes to requester 0 when all requesters are valid.
- Pointer skip: rr_ptr=2 with req_valid=4'b0011 -> grant goes to requester 0 and rr_ptr becomes 1.
